// File: rtl/otter_intr_pkg.sv
// Shared types and register map for the OTTER interrupt controller.
package otter_intr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } intr_state_t;

    localparam logic [1:0] OFF_PENDING = 2'd0;
    localparam logic [1:0] OFF_ENABLE  = 2'd1;
    localparam logic [1:0] OFF_CAUSE   = 2'd2;
    localparam logic [1:0] OFF_ACK     = 2'd3;

    localparam int CAUSE_VLD_BIT = 31;

endpackage

// File: rtl/intr_sync_edge.sv
// Three-flop synchronizer per line; rise is a one-cycle pulse on a synchronized 0->1.
module intr_sync_edge #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         RST,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] s1_q, s2_q, s3_q;

    always_ff @(posedge clk) begin
        if (RST) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/otter_intr_ctrl.sv
// Interrupt controller: edge-latched pending bits, enable mask, fixed priority (index 0 highest),
// intr/int_taken handshake and an ACK register that ends the service window.
module otter_intr_ctrl
    import otter_intr_pkg::*;
#(
    parameter int          N_SRC     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h1100_0100
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [31:0]      io_addr,
    input  logic [31:0]      io_wdata,
    input  logic             io_wr,
    input  logic             io_rd,
    output logic [31:0]      io_rdata,
    output logic             intr,
    input  logic             int_taken
);

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] enable_q, enable_d;
    logic [N_SRC-1:0] eligible, win_oh;
    logic [3:0]       cause_q, cause_d, win;
    logic [31:0]      rdata_q, rdata_d;
    intr_state_t      ps_q;
    logic             intr_q;
    logic             sel, wr_pend, wr_en, wr_ack, take, in_service;
    logic [1:0]       off;
    logic             unused_bits;

    intr_sync_edge #(.W(N_SRC)) u_sync (
        .clk    (clk),
        .RST    (RST),
        .d_i    (irq_src),
        .rise_o (rise)
    );

    assign sel        = (io_addr[31:4] == BASE_ADDR[31:4]);
    assign off        = io_addr[3:2];
    assign wr_pend    = io_wr && sel && (off == OFF_PENDING);
    assign wr_en      = io_wr && sel && (off == OFF_ENABLE);
    assign wr_ack     = io_wr && sel && (off == OFF_ACK);
    assign eligible   = pending_q & enable_q;
    assign in_service = (ps_q == SERVICE);
    assign take       = (ps_q == ASSERT) && int_taken && (|eligible);
    assign unused_bits = ^{io_addr[1:0], io_wdata};

    // Descending scan so the lowest eligible index is the last one written.
    always_comb begin
        win    = '0;
        win_oh = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win       = 4'(i);
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
        end
    end

    // Clears are applied before the new edges so a coincident rise survives.
    always_comb begin
        pending_d = pending_q;
        if (wr_pend) pending_d = pending_d & ~io_wdata[N_SRC-1:0];
        if (take)    pending_d = pending_d & ~win_oh;
        pending_d = pending_d | rise;

        enable_d = wr_en ? io_wdata[N_SRC-1:0] : enable_q;
        cause_d  = take ? win : cause_q;

        rdata_d = rdata_q;
        if (io_rd) begin
            rdata_d = '0;
            if (sel) begin
                case (off)
                    OFF_PENDING: rdata_d = 32'(pending_q);
                    OFF_ENABLE:  rdata_d = 32'(enable_q);
                    OFF_CAUSE: begin
                        rdata_d[3:0]          = cause_q;
                        rdata_d[CAUSE_VLD_BIT] = in_service;
                    end
                    default:     rdata_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            pending_q <= '0;
            enable_q  <= '0;
            cause_q   <= '0;
            rdata_q   <= '0;
        end else begin
            pending_q <= pending_d;
            enable_q  <= enable_d;
            cause_q   <= cause_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            ps_q   <= IDLE;
            intr_q <= 1'b0;
        end else begin
            case (ps_q)
                IDLE: begin
                    if (|eligible) begin
                        ps_q   <= ASSERT;
                        intr_q <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (take) begin
                        ps_q   <= SERVICE;
                        intr_q <= 1'b0;
                    end else if (~|eligible) begin
                        ps_q   <= IDLE;
                        intr_q <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (wr_ack) ps_q <= IDLE;
                    intr_q <= 1'b0;
                end
                default: begin
                    ps_q   <= IDLE;
                    intr_q <= 1'b0;
                end
            endcase
        end
    end

    assign intr     = intr_q;
    assign io_rdata = rdata_q;

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Directed bench for otter_intr_ctrl: a vector table for the basic take/ack flows plus hand-written corner sequences.
module tb_otter_intr_ctrl;

    localparam int          N    = 8;
    localparam logic [31:0] BASE = 32'h1100_0100;
    localparam logic [1:0]  P_PEND = 2'd0, P_EN = 2'd1, P_CAUSE = 2'd2, P_ACK = 2'd3;

    logic          clk = 1'b0;
    logic          RST;
    logic [N-1:0]  irq_src;
    logic [31:0]   io_addr, io_wdata, io_rdata;
    logic          io_wr, io_rd, intr, int_taken;

    int n_cmp = 0;
    int n_bad = 0;

    otter_intr_ctrl #(.N_SRC(N), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .RST       (RST),
        .irq_src   (irq_src),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_wr     (io_wr),
        .io_rd     (io_rd),
        .io_rdata  (io_rdata),
        .intr      (intr),
        .int_taken (int_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [1:0]  off;
        logic [31:0] wdata;
        logic [N-1:0] irq;
        logic        take;
        logic        exp_intr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t v(input logic wr, input logic rd, input logic [1:0] off,
                               input logic [31:0] wdata, input logic [N-1:0] irq,
                               input logic take, input logic exp_intr, input logic [31:0] exp_rdata);
        vec_t r;
        r.wr = wr; r.rd = rd; r.off = off; r.wdata = wdata; r.irq = irq;
        r.take = take; r.exp_intr = exp_intr; r.exp_rdata = exp_rdata;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [1:0] off, input logic [31:0] data);
        io_addr = BASE + 32'(off) * 4; io_wdata = data; io_wr = 1'b1;
        step();
        io_wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [1:0] off, output logic [31:0] data);
        io_addr = BASE + 32'(off) * 4; io_rd = 1'b1;
        step();
        io_rd = 1'b0;
        data = io_rdata;
    endtask

    initial begin
        logic [31:0] d;
        int hi_cnt;
        int waited;

        RST = 1'b1; irq_src = '0; io_addr = BASE; io_wdata = '0;
        io_wr = 1'b0; io_rd = 1'b0; int_taken = 1'b0;

        // Reset state
        step(); step();
        chk("rst_intr", 32'(intr), 32'h0);
        chk("rst_rdata", io_rdata, 32'h0);
        RST = 1'b0;
        rd_reg(P_PEND, d);  chk("rst_pending", d, 32'h0);
        rd_reg(P_EN, d);    chk("rst_enable", d, 32'h0);
        rd_reg(P_CAUSE, d); chk("rst_cause", d, 32'h0);

        // Single source take/ack, then two simultaneous sources with priority
        vecs[0]  = v(1, 0, P_EN,    32'hFF, 8'h00, 0, 0, 32'h0);
        vecs[1]  = v(0, 0, P_PEND,  32'h0,  8'h08, 0, 0, 32'h0);
        vecs[2]  = v(0, 0, P_PEND,  32'h0,  8'h08, 0, 0, 32'h0);
        vecs[3]  = v(0, 0, P_PEND,  32'h0,  8'h00, 0, 0, 32'h0);
        vecs[4]  = v(0, 1, P_PEND,  32'h0,  8'h00, 0, 1, 32'h08);
        vecs[5]  = v(0, 0, P_PEND,  32'h0,  8'h00, 1, 0, 32'h0);
        vecs[6]  = v(0, 1, P_CAUSE, 32'h0,  8'h00, 0, 0, 32'h8000_0003);
        vecs[7]  = v(0, 1, P_PEND,  32'h0,  8'h00, 0, 0, 32'h0);
        vecs[8]  = v(1, 0, P_ACK,   32'h0,  8'h00, 0, 0, 32'h0);
        vecs[9]  = v(0, 1, P_CAUSE, 32'h0,  8'h00, 0, 0, 32'h0000_0003);
        vecs[10] = v(0, 0, P_PEND,  32'h0,  8'h24, 0, 0, 32'h0);
        vecs[11] = v(0, 0, P_PEND,  32'h0,  8'h24, 0, 0, 32'h0);
        vecs[12] = v(0, 0, P_PEND,  32'h0,  8'h00, 0, 0, 32'h0);
        vecs[13] = v(0, 0, P_PEND,  32'h0,  8'h00, 0, 1, 32'h0);
        vecs[14] = v(0, 0, P_PEND,  32'h0,  8'h00, 1, 0, 32'h0);
        vecs[15] = v(0, 1, P_CAUSE, 32'h0,  8'h00, 0, 0, 32'h8000_0002);
        vecs[16] = v(0, 1, P_PEND,  32'h0,  8'h00, 0, 0, 32'h20);
        vecs[17] = v(0, 0, P_PEND,  32'h0,  8'h00, 1, 0, 32'h0);
        vecs[18] = v(1, 0, P_ACK,   32'h1,  8'h00, 0, 0, 32'h0);
        vecs[19] = v(0, 0, P_PEND,  32'h0,  8'h00, 0, 1, 32'h0);
        vecs[20] = v(0, 0, P_PEND,  32'h0,  8'h00, 1, 0, 32'h0);
        vecs[21] = v(0, 1, P_CAUSE, 32'h0,  8'h00, 0, 0, 32'h8000_0005);
        vecs[22] = v(1, 0, P_ACK,   32'h0,  8'h00, 0, 0, 32'h0);
        vecs[23] = v(0, 1, P_PEND,  32'h0,  8'h00, 0, 0, 32'h0);

        for (int i = 0; i < 24; i++) begin
            io_wr = vecs[i].wr; io_rd = vecs[i].rd;
            io_addr = BASE + 32'(vecs[i].off) * 4; io_wdata = vecs[i].wdata;
            irq_src = vecs[i].irq; int_taken = vecs[i].take;
            step();
            chk($sformatf("vec%0d_intr", i), 32'(intr), 32'(vecs[i].exp_intr));
            if (vecs[i].rd) chk($sformatf("vec%0d_rdata", i), io_rdata, vecs[i].exp_rdata);
        end
        io_wr = 1'b0; io_rd = 1'b0; irq_src = '0; int_taken = 1'b0;

        // Masked source, late enable, software W1C while asserted
        wr_reg(P_EN, 32'h00);
        irq_src = 8'h02; step(); step();
        irq_src = 8'h00; step(); step();
        rd_reg(P_PEND, d); chk("masked_pending", d, 32'h02);
        hi_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (intr) hi_cnt++;
        end
        chk("masked_intr_high_cycles", 32'(hi_cnt), 32'h0);
        wr_reg(P_EN, 32'h02);
        chk("enable_edge_intr", 32'(intr), 32'h0);
        step();
        chk("enable_next_intr", 32'(intr), 32'h1);
        wr_reg(P_PEND, 32'h02);
        step();
        chk("w1c_drop_intr", 32'(intr), 32'h0);
        rd_reg(P_CAUSE, d); chk("w1c_cause_idle", d, 32'h0000_0005);
        chk("w1c_stay_low", 32'(intr), 32'h0);

        // W1C coincident with a new edge: set wins
        irq_src = 8'h01; step(); step();
        wr_reg(P_PEND, 32'h01);
        rd_reg(P_PEND, d); chk("w1c_vs_rise", d, 32'h01);
        wr_reg(P_PEND, 32'h01);
        rd_reg(P_PEND, d); chk("w1c_no_rise", d, 32'h00);
        irq_src = 8'h00;

        // Reset while asserted; a later take is ignored
        wr_reg(P_EN, 32'hFF);
        irq_src = 8'h10; step(); step();
        irq_src = 8'h00;
        waited = 0;
        while (!intr && waited < 10) begin
            step();
            waited++;
        end
        chk("assert_before_rst", 32'(intr), 32'h1);
        RST = 1'b1; step(); RST = 1'b0;
        chk("rst_drops_intr", 32'(intr), 32'h0);
        rd_reg(P_EN, d); chk("rst_clears_enable", d, 32'h0);
        int_taken = 1'b1; step(); int_taken = 1'b0;
        rd_reg(P_CAUSE, d); chk("take_after_rst_cause", d, 32'h0);
        chk("take_after_rst_intr", 32'(intr), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/otter_intr_ctrl.md
Name: otter_intr_ctrl

Overview:
Interrupt controller for the RISC-V OTTER. It is the source end of the control unit's intr / int_taken handshake. It synchronizes external interrupt lines, latches rising edges as pending bits and masks them with an enable register. It drives intr to the control unit, captures the winning cause on int_taken, and holds off further interrupts until software acknowledges through a memory-mapped IO register.

Parameters:
N_SRC, 8, number of interrupt sources (1..16)
BASE_ADDR, 32'h1100_0100, IO base address, 16-byte aligned

Ports:
clk  input  1  system clock
RST  input  1  synchronous active-high reset
irq_src  input  N_SRC  asynchronous external interrupt lines, active high
io_addr  input  32  IO bus address
io_wdata  input  32  IO bus write data
io_wr  input  1  IO write strobe, one cycle
io_rd  input  1  IO read strobe, one cycle
io_rdata  output  32  registered read data
intr  output  1  interrupt request to control unit
int_taken  input  1  control unit has entered its interrupt state, one-cycle pulse

Behaviour:
- Reset (RST high at a clk edge):
  - all state clears: sync flops, pending, enable, cause, FSM = IDLE
  - intr = 0, io_rdata = 0
  - a source held high through reset registers as one edge after release
- Synchronizer, per source:
  - s1 <= irq_src, s2 <= s1, s3 <= s2
  - rise = s2 & ~s3
- pending[i] is set on rise[i].
  - Write of 1 to PENDING bit i clears it.
  - A set and a clear in the same cycle: set wins.
  - pending[win] also clears on the take event (see ASSERT).
- Register decode:
  - selected when io_addr[31:4] == BASE_ADDR[31:4]
  - offset = io_addr[3:2]
  - 0 PENDING: R / W1C
  - 1 ENABLE: RW, bits [N_SRC-1:0]
  - 2 CAUSE: RO; bit31 = in_service, bits[3:0] = cause index
  - 3 ACK: WO, any write; reads 0
- Bus widths and latency:
  - unused bits read 0; unused write bits are ignored
  - read latency 1: io_rdata updates at the edge after io_rd and holds until the next read
  - a write takes effect at the same edge as io_wr
- eligible = pending & enable.
- win = lowest set index of eligible; priority fixed, index 0 highest.
- FSM (package enum), intr = (PS == ASSERT), registered:
  - IDLE: eligible != 0 -> ASSERT. int_taken is ignored.
  - ASSERT:
    - int_taken && eligible != 0 -> SERVICE; cause <= win; pending[win] cleared at the same edge
    - else eligible == 0 (disabled or W1C by software) -> IDLE
    - else stay
  - SERVICE: intr = 0, in_service = 1. ACK write -> IDLE. int_taken is ignored.
- ACK write outside SERVICE: no effect.
- Cause is held until the next take.
- Latency: irq_src first sampled high at edge k gives:
  - pending set at edge k+2
  - intr high after edge k+3, if enabled and FSM in IDLE
- Writing ENABLE while in IDLE with pending nonzero: intr high one edge after the ENABLE write edge.

Decomposition:
- Package otter_intr_pkg holds:
  - intr_state_t enum {IDLE, ASSERT, SERVICE}
  - register offset constants OFF_PENDING=0, OFF_ENABLE=1, OFF_CAUSE=2, OFF_ACK=3
  - CAUSE valid-bit position 31
- One sub-module, intr_sync_edge, parameterized width:
  - 3-flop synchronizer plus rise output
  - synchronous reset on RST

Test Plan:
1. RST held 2 cycles with irq_src=0 -> intr=0, io_rdata=0; reads of PENDING, ENABLE and CAUSE all return 0.
2. ENABLE=0xFF; irq_src[3] high 2 cycles from edge k:
   - PENDING=0x08 after k+2; intr=1 after k+3
   - int_taken pulse -> next edge intr=0, CAUSE=0x8000_0003, PENDING=0
   - ACK write -> CAUSE bit31=0
3. ENABLE=0xFF; irq_src[5] and irq_src[2] rise together:
   - take -> CAUSE index 2, PENDING=0x20
   - intr stays 0 until ACK
   - after ACK, intr=1 within 1 edge; second take -> CAUSE index 5
4. ENABLE=0x00; irq_src[1] rises:
   - PENDING=0x02, intr stays 0 for 20 cycles
   - write ENABLE=0x02 -> intr=1 one edge later
   - write PENDING=0x02 while in ASSERT -> intr=0 next edge, FSM IDLE
5. Write PENDING=0x01 in the exact cycle rise[0] fires -> PENDING bit0 reads 1. A repeat W1C with no edge -> reads 0.
6. FSM in ASSERT (intr=1), RST asserted one cycle -> intr=0 and ENABLE=0 after that edge; int_taken pulse afterwards -> ignored, CAUSE=0.
